// File: rtl/mem_arb_pkg.sv
// Shared types and widths for the memory-port arbiter and its timeout counter.
package mem_arb_pkg;
  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam int STRB_W = 4;
  localparam int CNT_W  = 8;

  typedef enum logic [1:0] {
    ARB_IDLE = 2'd0,
    ARB_REQ  = 2'd1,
    ARB_WAIT = 2'd2
  } arb_state_e;

  typedef enum logic {
    OWN_IF = 1'b0,
    OWN_LS = 1'b1
  } owner_e;
endpackage

// File: rtl/mem_arb_timeout.sv
// Response-timeout counter: counts enabled cycles, flags expiry at TIMEOUT_CYCLES.
module mem_arb_timeout
  import mem_arb_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expired
);
  logic [CNT_W-1:0] cnt;

  // Saturates at the limit so a stalled owner cannot wrap the count.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt <= '0;
    end else if (en && !expired) begin
      cnt <= cnt + 1'b1;
    end
  end

  assign expired = (cnt == CNT_W'(TIMEOUT_CYCLES));
endmodule

// File: rtl/mem_port_arbiter.sv
// Arbiter/sequencer sharing one memory port between fetch (IF) and load/store (LS).
// Define MEM_PORT_ARB_RR_EN for round-robin contention; default is LS-priority.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_gnt,
  output logic              if_rvalid,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              ls_req,
  input  logic              ls_we,
  input  logic [ADDR_W-1:0] ls_addr,
  input  logic [DATA_W-1:0] ls_wdata,
  input  logic [STRB_W-1:0] ls_wstrb,
  output logic              ls_gnt,
  output logic              ls_rvalid,
  output logic [DATA_W-1:0] ls_rdata,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic [STRB_W-1:0] mem_wstrb,
  input  logic              mem_ready,
  input  logic              mem_rvalid,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              mux_sel,
  output logic              arb_err
);
  arb_state_e        state, state_nxt;
  owner_e            owner;
  logic              grant_if, grant_ls;
  logic              expired;
  logic              resp;
  logic [DATA_W-1:0] resp_data;
  logic [ADDR_W-1:0] lat_addr;
  logic [DATA_W-1:0] lat_wdata;
  logic [STRB_W-1:0] lat_wstrb;
  logic              lat_we;

`ifdef MEM_PORT_ARB_RR_EN
  owner_e last_owner;

  always_ff @(posedge clk) begin
    if (rst) begin
      last_owner <= OWN_LS;
    end else if (grant_if) begin
      last_owner <= OWN_IF;
    end else if (grant_ls) begin
      last_owner <= OWN_LS;
    end
  end
`endif

  // Grants are combinational in IDLE; nothing is granted during a reset cycle.
  always_comb begin
    grant_if = 1'b0;
    grant_ls = 1'b0;
    if (state == ARB_IDLE && !rst) begin
      if (if_req && ls_req) begin
`ifdef MEM_PORT_ARB_RR_EN
        if (last_owner == OWN_IF) grant_ls = 1'b1;
        else                      grant_if = 1'b1;
`else
        grant_ls = 1'b1;
`endif
      end else begin
        grant_if = if_req;
        grant_ls = ls_req;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    resp      = 1'b0;
    resp_data = '0;
    arb_err   = 1'b0;
    case (state)
      ARB_IDLE: if (grant_if || grant_ls) state_nxt = ARB_REQ;
      ARB_REQ:  if (mem_ready) state_nxt = ARB_WAIT;
      ARB_WAIT: begin
        // A real response wins over an expiry landing in the same cycle.
        if (mem_rvalid) begin
          resp      = 1'b1;
          resp_data = mem_rdata;
          state_nxt = ARB_IDLE;
        end else if (expired) begin
          resp      = 1'b1;
          arb_err   = 1'b1;
          state_nxt = ARB_IDLE;
        end
      end
      default: state_nxt = ARB_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ARB_IDLE;
      owner <= OWN_IF;
    end else begin
      state <= state_nxt;
      if (grant_if)      owner <= OWN_IF;
      else if (grant_ls) owner <= OWN_LS;
    end
  end

  // Request payload is only visible in REQ, so it needs no reset.
  always_ff @(posedge clk) begin
    if (grant_ls) begin
      lat_addr  <= ls_addr;
      lat_we    <= ls_we;
      lat_wdata <= ls_wdata;
      lat_wstrb <= ls_wstrb;
    end else if (grant_if) begin
      lat_addr  <= if_addr;
      lat_we    <= 1'b0;
      lat_wdata <= '0;
      lat_wstrb <= '0;
    end
  end

  mem_arb_timeout #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_timeout (
    .clk     (clk),
    .rst     (rst),
    .clr     (state != ARB_WAIT),
    .en      (state == ARB_WAIT),
    .expired (expired)
  );

  assign if_gnt    = grant_if;
  assign ls_gnt    = grant_ls;
  assign mux_sel   = owner;
  assign if_rvalid = resp && (owner == OWN_IF);
  assign ls_rvalid = resp && (owner == OWN_LS);
  assign if_rdata  = (resp && owner == OWN_IF) ? resp_data : '0;
  assign ls_rdata  = (resp && owner == OWN_LS) ? resp_data : '0;
  assign mem_req   = (state == ARB_REQ);
  assign mem_we    = mem_req ? lat_we    : 1'b0;
  assign mem_addr  = mem_req ? lat_addr  : '0;
  assign mem_wdata = mem_req ? lat_wdata : '0;
  assign mem_wstrb = mem_req ? lat_wstrb : '0;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: random requesters and memory against a queue-based model.
module tb_mem_port_arbiter;
  import mem_arb_pkg::*;

  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        if_req = 1'b0;
  logic [31:0] if_addr = '0;
  logic        if_gnt, if_rvalid;
  logic [31:0] if_rdata;
  logic        ls_req = 1'b0, ls_we = 1'b0;
  logic [31:0] ls_addr = '0, ls_wdata = '0;
  logic [3:0]  ls_wstrb = '0;
  logic        ls_gnt, ls_rvalid;
  logic [31:0] ls_rdata;
  logic        mem_req, mem_we;
  logic [31:0] mem_addr, mem_wdata;
  logic [3:0]  mem_wstrb;
  logic        mem_ready = 1'b0, mem_rvalid = 1'b0;
  logic [31:0] mem_rdata = '0;
  logic        mux_sel, arb_err;

  mem_port_arbiter #(.TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_rvalid(if_rvalid), .if_rdata(if_rdata),
    .ls_req(ls_req), .ls_we(ls_we), .ls_addr(ls_addr), .ls_wdata(ls_wdata), .ls_wstrb(ls_wstrb),
    .ls_gnt(ls_gnt), .ls_rvalid(ls_rvalid), .ls_rdata(ls_rdata),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_wstrb(mem_wstrb), .mem_ready(mem_ready), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
    .mux_sel(mux_sel), .arb_err(arb_err)
  );

  typedef struct {
    bit          own;
    logic [31:0] addr;
    logic        we;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
  } req_t;

  typedef struct {
    int          cyc;
    bit          own;
    logic [31:0] data;
    bit          err;
  } rsp_t;

  req_t        req_q[$];
  rsp_t        rsp_q[$];
  int          n_cmp = 0, n_bad = 0, cyc = 0;
  bit          busy = 0, in_req = 0, mux_exp = 0, last_own = 1, if_got = 0, ls_got = 0;
  int          rsp_at = -1, late_at = -1, acc_cyc = -1;
  logic [31:0] rsp_data = '0;
  int          rdy_force = -1, dly_force = -1;
  bit          data_force_en = 0;
  logic [31:0] data_force = '0;
  int          p_if = 0, p_ls = 0, p_drop = 0;
  bit          w_if, w_ls;
  req_t        r;
  rsp_t        s;
  int          k;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s cyc=%0d got=%h expected=%h", name, cyc, act, exp);
    end
  endfunction

  function automatic void chk1(string name, logic act, logic exp);
    check(name, {31'd0, act}, {31'd0, exp});
  endfunction

  // Memory responder: drives after the main process so stimulus settings apply this cycle.
  initial begin
    forever begin
      @(posedge clk);
      #2;
      mem_ready  = (rdy_force >= 0) ? (rdy_force != 0) : ($urandom_range(0, 3) != 0);
      mem_rvalid = (cyc == rsp_at) || (cyc == late_at);
      mem_rdata  = (cyc == rsp_at) ? rsp_data : $urandom;
    end
  end

  // Monitor and reference model, sampled mid-cycle.
  always @(negedge clk) begin
    if (rst) begin
      busy = 0; in_req = 0; mux_exp = 0; last_own = 1;
      if_got = 0; ls_got = 0; rsp_at = -1; late_at = -1;
      req_q.delete();
      rsp_q.delete();
    end else begin
      w_if = 0;
      w_ls = 0;
      if (!busy) begin
        if (if_req && ls_req) begin
`ifdef MEM_PORT_ARB_RR_EN
          if (last_own) w_if = 1; else w_ls = 1;
`else
          w_ls = 1;
`endif
        end else begin
          w_if = if_req;
          w_ls = ls_req;
        end
      end
      chk1("if_gnt", if_gnt, w_if);
      chk1("ls_gnt", ls_gnt, w_ls);
      chk1("mux_sel", mux_sel, mux_exp);

      if (in_req && req_q.size() > 0) begin
        chk1("mem_req", mem_req, 1'b1);
        check("mem_addr", mem_addr, req_q[0].addr);
        chk1("mem_we", mem_we, req_q[0].we);
        check("mem_wstrb", {28'd0, mem_wstrb}, {28'd0, req_q[0].wstrb});
        if (req_q[0].we) check("mem_wdata", mem_wdata, req_q[0].wdata);
        if (mem_ready) begin
          r = req_q.pop_front();
          in_req = 0;
          acc_cyc = cyc;
          if (dly_force == 0 || (dly_force < 0 && $urandom_range(0, 7) == 0)) begin
            rsp_at  = -1;
            late_at = cyc + TO + 2;
            s.cyc = cyc + TO + 1; s.own = r.own; s.data = '0; s.err = 1;
          end else begin
            k = (dly_force > 0) ? dly_force : int'($urandom_range(1, 4));
            rsp_at   = cyc + k;
            rsp_data = data_force_en ? data_force : $urandom;
            s.cyc = cyc + k; s.own = r.own; s.data = rsp_data; s.err = 0;
          end
          rsp_q.push_back(s);
        end
      end else begin
        chk1("mem_req_idle", mem_req, 1'b0);
        check("mem_addr_idle", mem_addr, 32'd0);
        check("mem_wdata_idle", mem_wdata, 32'd0);
        chk1("mem_we_idle", mem_we, 1'b0);
        check("mem_wstrb_idle", {28'd0, mem_wstrb}, 32'd0);
      end

      if (rsp_q.size() > 0 && rsp_q[0].cyc == cyc) begin
        s = rsp_q.pop_front();
        chk1("if_rvalid", if_rvalid, !s.own);
        chk1("ls_rvalid", ls_rvalid, s.own);
        check("if_rdata", if_rdata, s.own ? 32'd0 : s.data);
        check("ls_rdata", ls_rdata, s.own ? s.data : 32'd0);
        chk1("arb_err", arb_err, s.err);
        busy = 0;
      end else begin
        chk1("if_rvalid_quiet", if_rvalid, 1'b0);
        chk1("ls_rvalid_quiet", ls_rvalid, 1'b0);
        check("if_rdata_quiet", if_rdata, 32'd0);
        check("ls_rdata_quiet", ls_rdata, 32'd0);
        chk1("arb_err_quiet", arb_err, 1'b0);
      end

      if (w_if || w_ls) begin
        r.own   = w_ls;
        r.addr  = w_ls ? ls_addr : if_addr;
        r.we    = w_ls ? ls_we : 1'b0;
        r.wdata = ls_wdata;
        r.wstrb = w_ls ? ls_wstrb : 4'd0;
        req_q.push_back(r);
        busy = 1;
        in_req = 1;
        mux_exp = w_ls;
        last_own = w_ls;
        if (w_if) if_got = 1;
        if (w_ls) ls_got = 1;
      end
    end
  end

  task automatic req_step();
    if (if_got) begin
      if_req = 0; if_got = 0;
    end else if (if_req && int'($urandom_range(0, 99)) < p_drop) begin
      if_req = 0;
    end
    if (!if_req && int'($urandom_range(0, 99)) < p_if) begin
      if_req = 1; if_addr = $urandom;
    end
    if (ls_got) begin
      ls_req = 0; ls_got = 0;
    end else if (ls_req && int'($urandom_range(0, 99)) < p_drop) begin
      ls_req = 0;
    end
    if (!ls_req && int'($urandom_range(0, 99)) < p_ls) begin
      ls_req = 1; ls_addr = $urandom; ls_we = 1'($urandom);
      ls_wdata = $urandom; ls_wstrb = 4'($urandom);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    req_step();
  endtask

  task automatic drain();
    int n;
    n = 0;
    p_if = 0; p_ls = 0; p_drop = 0;
    while ((busy || if_req || ls_req) && n < 300) begin
      step();
      n++;
    end
    chk1("drain_bound", busy || if_req || ls_req, 1'b0);
  endtask

  initial begin
    #1000000;
    $display("FAIL global_timeout cyc=%0d", cyc);
    $fatal(1, "time limit");
  end

  initial begin
    int n;
    repeat (3) @(posedge clk);
    #1;
    rst = 0;
    repeat (3) step();

    // Single IF read, zero-wait memory
    rdy_force = 1; dly_force = 1; data_force_en = 1; data_force = 32'hDEADBEEF;
    if_req = 1; if_addr = 32'h100;
    drain();
    data_force_en = 0;

    // LS write with ready held low for three REQ cycles
    rdy_force = 0; dly_force = 2;
    ls_req = 1; ls_we = 1; ls_addr = 32'h2000; ls_wdata = 32'h12345678; ls_wstrb = 4'b0011;
    repeat (4) step();
    rdy_force = 1;
    drain();

    // Continuous contention
    rdy_force = -1; dly_force = -1;
    p_if = 100; p_ls = 100;
    repeat (40) step();
    drain();

    // Timeouts with a late response afterwards
    dly_force = 0;
    if_req = 1; if_addr = $urandom;
    drain();
    ls_req = 1; ls_we = 0; ls_addr = $urandom;
    drain();

    // Reset while waiting for a response
    rdy_force = 1; acc_cyc = -1;
    if_req = 1; if_addr = 32'h300;
    n = 0;
    while (acc_cyc < 0 && n < 20) begin
      step();
      n++;
    end
    chk1("accept_bound", acc_cyc < 0, 1'b0);
    repeat (2) step();
    rst = 1;
    step();
    rst = 0;
    dly_force = -1;
    if_req = 1; if_addr = 32'h400;
    drain();

    // LS request withdrawn while IF owns the port
    dly_force = 2;
    if_req = 1; if_addr = 32'h500;
    step();
    ls_req = 1; ls_addr = 32'h600; ls_we = 1;
    repeat (2) step();
    ls_req = 0;
    drain();

    // Random traffic
    rdy_force = -1; dly_force = -1;
    p_if = 40; p_ls = 40; p_drop = 10;
    repeat (1500) step();
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
